imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode stage. It accepts instruction bits ins[31:7] and an immediate-type code over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width one cycle later, with a two-entry skid buffer for full throughput under backpressure. Compared with the combinational imm_gen, it adds 64-bit extension, CSR zimm and shift-amount types, a passthrough tag, and flush.

---
 rtl/imm_gen_pipe.sv | 137 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for decode: computes the XLEN-wide immediate at
// acceptance and buffers results in a two-entry (main + skid) valid/ready pipe.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_imm_type,
    input  logic [24:0]      in_ins,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_type,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned TYPE_W = 3;

    localparam logic [TYPE_W-1:0] IMM_I_TYPE  = 3'd0;
    localparam logic [TYPE_W-1:0] IMM_S_TYPE  = 3'd1;
    localparam logic [TYPE_W-1:0] IMM_B_TYPE  = 3'd2;
    localparam logic [TYPE_W-1:0] IMM_U_TYPE  = 3'd3;
    localparam logic [TYPE_W-1:0] IMM_J_TYPE  = 3'd4;
    localparam logic [TYPE_W-1:0] IMM_Z_TYPE  = 3'd5;
    localparam logic [TYPE_W-1:0] IMM_SH_TYPE = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]   imm;
        logic [TYPE_W-1:0] imm_type;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;

    logic [31:7]     ins;
    logic [XLEN-1:0] imm_c;
    entry_t          new_entry_c;
    logic            accept_c;
    logic            deliver_c;

    assign ins = in_ins;

    // Immediate decode; sized casts of signed slices replicate ins[31] up to XLEN-1.
    always_comb begin
        imm_c = '0;
        case (in_imm_type)
            IMM_I_TYPE:  imm_c = XLEN'($signed(ins[31:20]));
            IMM_S_TYPE:  imm_c = XLEN'($signed({ins[31:25], ins[11:7]}));
            IMM_B_TYPE:  imm_c = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            IMM_U_TYPE:  imm_c = XLEN'($signed({ins[31:12], 12'b0}));
            IMM_J_TYPE:  imm_c = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            IMM_Z_TYPE:  imm_c = XLEN'(ins[19:15]);
            IMM_SH_TYPE: begin
                if (XLEN == 64) imm_c = XLEN'(ins[25:20]);
                else            imm_c = XLEN'(ins[24:20]);
            end
            default:     imm_c = '0;
        endcase
    end

    assign new_entry_c = '{imm: imm_c, imm_type: in_imm_type, tag: in_tag};
    assign accept_c    = in_valid && in_ready_q;
    assign deliver_c   = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next state; flush overrides any same-cycle accept or deliver.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    main_d  = new_entry_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (deliver_c && accept_c) begin
                    main_d = new_entry_c;
                end else if (deliver_c) begin
                    state_d = EMPTY;
                end else if (accept_c) begin
                    skid_d  = new_entry_c;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (deliver_c) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_tag      = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share all inputs.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_imm_type;
    logic [24:0] in_ins;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_type32, out_type64;
    logic [31:0] out_tag32, out_tag64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_imm_type(in_imm_type),
        .in_ins(in_ins), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_imm_type(out_type32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_imm_type(in_imm_type),
        .in_ins(in_ins), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_imm_type(out_type64), .out_tag(out_tag64)
    );

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] w,
                         input logic [31:0] tag, input logic ordy);
        in_valid    = v;
        in_imm_type = t;
        in_ins      = w[31:7];
        in_tag      = tag;
        out_ready   = ordy;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk); @(negedge clk);
        vectors++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hs: out_valid=%b/%b in_ready=%b/%b, required 0/0 1/1",
                     out_valid32, out_valid64, in_ready32, in_ready64);
        end
        vectors++;
        if (out_imm32 !== 32'h0 || out_imm64 !== 64'h0 || out_tag32 !== 32'h0 || out_type32 !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_fields: imm=%h/%h tag=%h type=%0d, required all zero",
                     out_imm32, out_imm64, out_tag32, out_type32);
        end
        rst = 1'b0;
    endtask

    task automatic test_i_type;
        logic [31:0] w   [2] = '{32'hfec42703, 32'h7ff00713};
        logic [31:0] e32 [2] = '{32'hffffffec, 32'h000007ff};
        logic [63:0] e64 [2] = '{64'hffffffffffffffec, 64'h00000000000007ff};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd0, w[i], 32'h100 + 32'(i), 1'b1);
            @(negedge clk);
            vectors++;
            if (out_valid32 !== 1'b1 || out_imm32 !== e32[i] || out_imm64 !== e64[i] || out_tag32 !== 32'h100 + 32'(i)) begin
                miscompares++;
                $display("FAIL i_type[%0d]: valid=%b imm32=%h imm64=%h tag=%h, required 1 %h %h %h",
                         i, out_valid32, out_imm32, out_imm64, out_tag32, e32[i], e64[i], 32'h100 + 32'(i));
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_valid32 !== 1'b0) begin
            miscompares++;
            $display("FAIL i_type_drain: out_valid=%b, required 0", out_valid32);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  t   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] w   [4] = '{32'h00812e23, 32'hfee79ee3, 32'h00001737, 32'hff5ff06f};
        logic [31:0] e32 [4] = '{32'h0000001c, 32'hfffffffc, 32'h00001000, 32'hfffffff4};
        logic [63:0] e64 [4] = '{64'h1c, 64'hfffffffffffffffc, 64'h1000, 64'hfffffffffffffff4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t[i], w[i], 32'h200 + 32'(i), 1'b1);
            @(negedge clk);
            vectors++;
            if (out_valid32 !== 1'b1 || in_ready32 !== 1'b1 || out_imm32 !== e32[i] || out_imm64 !== e64[i]
                || out_tag64 !== 32'h200 + 32'(i) || out_type64 !== t[i]) begin
                miscompares++;
                $display("FAIL stream[%0d]: valid=%b rdy=%b imm32=%h imm64=%h tag=%h type=%0d, required 1 1 %h %h %h %0d",
                         i, out_valid32, in_ready32, out_imm32, out_imm64, out_tag64, out_type64,
                         e32[i], e64[i], 32'h200 + 32'(i), t[i]);
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_new_types;
        logic [2:0]  t   [3] = '{3'd5, 3'd6, 3'd7};
        logic [31:0] e32 [3] = '{32'd31, 32'd31, 32'd0};
        logic [63:0] e64 [3] = '{64'd31, 64'd63, 64'd0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, t[i], 32'hffffffff, 32'h300 + 32'(i), 1'b1);
            @(negedge clk);
            vectors++;
            if (out_valid64 !== 1'b1 || out_imm32 !== e32[i] || out_imm64 !== e64[i] || out_type32 !== t[i]) begin
                miscompares++;
                $display("FAIL new_type[%0d]: valid=%b imm32=%h imm64=%h type=%0d, required 1 %h %h %0d",
                         i, out_valid64, out_imm32, out_imm64, out_type32, e32[i], e64[i], t[i]);
            end
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [31:0] w   [4] = '{32'h00100013, 32'h00200013, 32'h7f000013, 32'h80000013};
        logic [31:0] e32 [4] = '{32'h00000001, 32'h00000002, 32'h000007f0, 32'hfffff800};
        // per step: drive valid, drive index, out_ready, expected out_valid, expected index, expected in_ready
        logic        dv [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int          di [8] = '{0, 1, 2, 2, 2, 2, 3, 0};
        logic        dr [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        logic        ev [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int          ei [8] = '{0, 0, 0, 0, 1, 2, 3, 0};
        logic        er [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        for (int s = 0; s < 8; s++) begin
            drive(dv[s], 3'd0, w[di[s]], 32'h400 + 32'(di[s]), dr[s]);
            @(negedge clk);
            vectors++;
            if (out_valid32 !== ev[s] || in_ready32 !== er[s]
                || (ev[s] && (out_imm32 !== e32[ei[s]] || out_tag32 !== 32'h400 + 32'(ei[s])))) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: valid=%b rdy=%b imm=%h tag=%h, required %b %b %h %h",
                         s, out_valid32, in_ready32, out_imm32, out_tag32, ev[s], er[s],
                         e32[ei[s]], 32'h400 + 32'(ei[s]));
            end
        end
    endtask

    task automatic test_flush;
        drive(1'b1, 3'd0, 32'h00100013, 32'h500, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd0, 32'h00200013, 32'h501, 1'b0);
        @(negedge clk);
        vectors++;
        if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_fill: in_ready=%b out_valid=%b, required 0 1", in_ready32, out_valid32);
        end
        flush = 1'b1;
        drive(1'b1, 3'd0, 32'h00300013, 32'h502, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clear: out_valid=%b in_ready=%b, required 0 1", out_valid32, in_ready32);
        end
        flush = 1'b0;
        drive(1'b1, 3'd0, 32'h05500013, 32'h503, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'h00000055 || out_tag32 !== 32'h503) begin
            miscompares++;
            $display("FAIL flush_new: valid=%b imm=%h tag=%h, required 1 00000055 00000503",
                     out_valid32, out_imm32, out_tag32);
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        vectors++;
        if (out_valid32 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drain: out_valid=%b tag=%h, required 0", out_valid32, out_tag32);
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'd0, 32'hfec42703, 32'h600, 1'b0);
            @(negedge clk);
            vectors++;
            if (out_valid32 !== 1'b1 || out_imm32 !== 32'hffffffec) begin
                miscompares++;
                $display("FAIL rst_mid_fill[%0d]: valid=%b imm=%h, required 1 ffffffec", k, out_valid32, out_imm32);
            end
            rst = 1'b1;
            flush = (k == 1);
            drive(1'b1, 3'd0, 32'h7ff00713, 32'h601, 1'b0);
            @(negedge clk);
            vectors++;
            if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_imm32 !== 32'h0 || out_imm64 !== 64'h0
                || out_tag32 !== 32'h0 || out_type32 !== 3'd0 || out_valid64 !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid[%0d]: valid=%b rdy=%b imm=%h/%h tag=%h type=%0d, required 0 1 and zero fields",
                         k, out_valid32, in_ready32, out_imm32, out_imm64, out_tag32, out_type32);
            end
            rst = 1'b0;
            flush = 1'b0;
            drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        test_reset;
        test_i_type;
        test_back_to_back;
        test_new_types;
        test_backpressure;
        test_flush;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
